demux_xor_arbiter: RTL and testbench

DEMUX_XOR_ARBITER -- requirements
Module: demux_xor_arbiter

---
 rtl/demux_xor_arbiter.sv | 108 ++++++++++
 tb/tb_demux_xor_arbiter.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/demux_xor_arbiter.sv
// Four-requester round-robin arbiter feeding a single XOR/XNOR unit; the
// completion pulse is demuxed back to the requester that was granted.
module demux_xor_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [3:0]           req,
    input  logic [4*WIDTH-1:0]   a_in,
    input  logic [4*WIDTH-1:0]   b_in,
    output logic [3:0]           gnt,
    output logic [3:0]           done,
    output logic                 rsp_valid,
    output logic [1:0]           rsp_id,
    output logic [WIDTH-1:0]     xor_o,
    output logic [WIDTH-1:0]     xnor_o,
    output logic                 busy
);
    localparam int NREQ = 4;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        DONE = 2'b10
    } state_t;

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } opnd_t;

    state_t                state;
    opnd_t [NREQ-1:0]      lane;
    opnd_t                 cap;
    logic [1:0]            ptr;
    logic [1:0]            win_id;
    logic [1:0]            idx;
    logic                  win_vld;

    for (genvar i = 0; i < NREQ; i++) begin : g_lane
        assign lane[i].a = a_in[i*WIDTH +: WIDTH];
        assign lane[i].b = b_in[i*WIDTH +: WIDTH];
    end

    // Rotating search starting at ptr: the only tie-break, so no fixed priority.
    always_comb begin
        win_vld = 1'b0;
        win_id  = 2'd0;
        idx     = 2'd0;
        for (int k = 0; k < NREQ; k++) begin
            idx = ptr + 2'(k);
            if (!win_vld && req[idx]) begin
                win_vld = 1'b1;
                win_id  = idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= 2'd0;
            gnt       <= 4'd0;
            done      <= 4'd0;
            rsp_valid <= 1'b0;
            rsp_id    <= 2'd0;
            xor_o     <= '0;
            xnor_o    <= '1;
            cap       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_vld) begin
                        cap    <= lane[win_id];
                        gnt    <= 4'(1) << win_id;
                        rsp_id <= win_id;
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    // Result comes only from the captured operands, so late input changes are ignored.
                    xor_o     <= cap.a ^ cap.b;
                    xnor_o    <= ~(cap.a ^ cap.b);
                    gnt       <= 4'd0;
                    done      <= 4'(1) << rsp_id;
                    rsp_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    done      <= 4'd0;
                    rsp_valid <= 1'b0;
                    ptr       <= rsp_id + 2'd1;
                    rsp_id    <= 2'd0;
                    state     <= IDLE;
                end
                default: begin
                    gnt       <= 4'd0;
                    done      <= 4'd0;
                    rsp_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_demux_xor_arbiter.sv
// Directed bench for demux_xor_arbiter: arbitration order, latency, operand
// capture, XOR/XNOR results and reset behaviour with hand-computed values.
module tb_demux_xor_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [31:0] a_in, b_in;
    logic [3:0]  gnt, done;
    logic        rsp_valid;
    logic [1:0]  rsp_id;
    logic [7:0]  xor_o, xnor_o;
    logic        busy;

    int n_chk  = 0;
    int n_fail = 0;

    demux_xor_arbiter #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .a_in(a_in), .b_in(b_in),
        .gnt(gnt), .done(done), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
        .xor_o(xor_o), .xnor_o(xnor_o), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One full transaction: arbitration edge, EXEC edge, DONE edge.
    task automatic serve(input int id, input logic [31:0] a_mid, input logic [3:0] req_after,
                         input logic [7:0] exp_x);
        logic [3:0] oh;
        oh = 4'b0001 << id;
        tick;
        check("gnt", {28'd0, gnt}, {28'd0, oh});
        check("gnt_id", {30'd0, rsp_id}, id);
        check("gnt_done0", {28'd0, done}, 0);
        check("gnt_busy", {31'd0, busy}, 1);
        a_in = a_mid;
        tick;
        check("done", {28'd0, done}, {28'd0, oh});
        check("done_gnt0", {28'd0, gnt}, 0);
        check("rsp_valid", {31'd0, rsp_valid}, 1);
        check("done_id", {30'd0, rsp_id}, id);
        check("xor", {24'd0, xor_o}, {24'd0, exp_x});
        check("xnor", {24'd0, xnor_o}, {24'd0, ~exp_x});
        check("done_busy", {31'd0, busy}, 1);
        req = req_after;
        tick;
        check("post_done", {28'd0, done}, 0);
        check("post_valid", {31'd0, rsp_valid}, 0);
        check("post_busy", {31'd0, busy}, 0);
        check("post_xor", {24'd0, xor_o}, {24'd0, exp_x});
    endtask

    initial begin
        rst_n = 1'b0; req = 4'd0; a_in = 32'd0; b_in = 32'd0;
        tick; tick;
        check("rst_gnt", {28'd0, gnt}, 0);
        check("rst_done", {28'd0, done}, 0);
        check("rst_valid", {31'd0, rsp_valid}, 0);
        check("rst_id", {30'd0, rsp_id}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_xor", {24'd0, xor_o}, 32'h00);
        check("rst_xnor", {24'd0, xnor_o}, 32'hFF);

        // Single request, requester 0.
        rst_n = 1'b1; req = 4'b0001; a_in = 32'h000000A5; b_in = 32'h0000000F;
        serve(0, a_in, 4'b0000, 8'hAA);
        tick;
        check("idle_gnt", {28'd0, gnt}, 0);
        check("idle_busy", {31'd0, busy}, 0);
        check("idle_xor_hold", {24'd0, xor_o}, 32'hAA);

        // All four requesting from reset: strict rotation 0,1,2,3,0.
        rst_n = 1'b0; req = 4'b1111;
        a_in = 32'h44332211; b_in = 32'h0FF00FF0;
        tick;
        rst_n = 1'b1;
        serve(0, a_in, 4'b1111, 8'hE1);
        serve(1, a_in, 4'b1111, 8'h2D);
        serve(2, a_in, 4'b1111, 8'hC3);
        serve(3, a_in, 4'b1111, 8'h4B);
        serve(0, a_in, 4'b0010, 8'hE1);

        // Serve 1 (ptr -> 2), then req=1011 must go 3, 0, 1.
        serve(1, a_in, 4'b1011, 8'h2D);
        serve(3, a_in, 4'b0011, 8'h4B);
        serve(0, a_in, 4'b0010, 8'hE1);
        serve(1, a_in, 4'b0000, 8'h2D);

        // A3 changes during EXEC; captured 0xFF must be used.
        req = 4'b1000; a_in = 32'hFF000000; b_in = 32'hF0000000;
        serve(3, 32'h00000000, 4'b0000, 8'h0F);

        // Equal operands, then complementary operands.
        req = 4'b0001; a_in = 32'h0000003C; b_in = 32'h0000003C;
        serve(0, a_in, 4'b0000, 8'h00);
        req = 4'b0010; a_in = 32'h00000000; b_in = 32'h0000FF00;
        serve(1, a_in, 4'b0000, 8'hFF);

        // Reset during DONE of requester 2 aborts it; req held, re-granted afterwards.
        req = 4'b0100; a_in = 32'h00120000; b_in = 32'h00340000;
        tick;
        check("r2_gnt", {28'd0, gnt}, 32'h4);
        tick;
        check("r2_done", {28'd0, done}, 32'h4);
        rst_n = 1'b0;
        tick;
        check("rd_done", {28'd0, done}, 0);
        check("rd_valid", {31'd0, rsp_valid}, 0);
        check("rd_busy", {31'd0, busy}, 0);
        check("rd_xor", {24'd0, xor_o}, 32'h00);
        check("rd_xnor", {24'd0, xnor_o}, 32'hFF);
        rst_n = 1'b1;
        serve(2, a_in, 4'b0000, 8'h26);

        // Reset during EXEC: no done pulse, result registers stay at reset values.
        req = 4'b0001; a_in = 32'h00000081; b_in = 32'h00000018;
        tick;
        check("re_gnt", {28'd0, gnt}, 32'h1);
        rst_n = 1'b0;
        tick;
        check("re_done", {28'd0, done}, 0);
        check("re_gnt0", {28'd0, gnt}, 0);
        check("re_xnor", {24'd0, xnor_o}, 32'hFF);
        rst_n = 1'b1;
        serve(0, a_in, 4'b0000, 8'h99);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
